// File: rtl/uart_echo_fifo_if.sv
// Host-side word interface of uart_echo_fifo: a TX write handshake and an RX FIFO read
// handshake.
interface uart_echo_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART transceiver with 16x oversampled receiver, RX FIFO, host word port and a hardware
// echo path that retransmits received words when echo_en is high.
module uart_echo_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          echo_en,
  uart_echo_fifo_if.slave               host,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  input  logic                          clear_err
);

  localparam int unsigned DIV     = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam bit          HAS_PAR = (PARITY != 0);

  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 2) ? ~(^w) : (^w);
  endfunction

  // Free-running oversample tick generator
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  // Receiver FSM
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  rx_state_e            rx_state_q;
  logic [3:0]           rx_tick_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;
  logic                 rx_push_q;
  logic [DATA_BITS-1:0] rx_word_q;
  logic                 rx_frame_ev_q;
  logic                 rx_par_ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= RxIdle;
      rx_tick_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_push_q     <= 1'b0;
      rx_word_q     <= '0;
      rx_frame_ev_q <= 1'b0;
      rx_par_ev_q   <= 1'b0;
    end else begin
      rx_push_q     <= 1'b0;
      rx_frame_ev_q <= 1'b0;
      rx_par_ev_q   <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (start_edge) begin
            rx_state_q <= RxStart;
            rx_tick_q  <= '0;
          end
        end
        RxStart: begin
          if (tick) begin
            if (rx_tick_q == 4'd7) begin
              // Re-centre the tick count on mid-bit; a high sample was a glitch
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_sync_q ? RxIdle : RxData;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        RxData: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_q   <= rx_bit_q + 4'd1;
              if (rx_bit_q == 4'(DATA_BITS - 1)) begin
                rx_state_q <= HAS_PAR ? RxParity : RxStop;
              end
            end
          end
        end
        RxParity: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_par_q   <= rx_sync_q;
              rx_state_q <= RxStop;
            end
          end
        end
        RxStop: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_state_q    <= RxIdle;
              rx_push_q     <= 1'b1;
              rx_word_q     <= rx_shift_q;
              rx_frame_ev_q <= ~rx_sync_q;
              rx_par_ev_q   <= HAS_PAR && (rx_par_q != par_of(rx_shift_q));
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // RX FIFO; pointers carry one extra wrap bit so full and empty are distinct
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [LVL_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 empty, full;
  logic                 host_pop, echo_pop, pop;
  logic                 push_ok, overrun_ev;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign pop        = host_pop | echo_pop;
  assign push_ok    = rx_push_q & (~full | pop);
  assign overrun_ev = rx_push_q & full & ~pop;
  assign rd_ptr_d   = rd_ptr_q + {{(LVL_W-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_word_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      // Head register: bypass a write that lands in the slot about to become the head
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_q <= rx_word_q;
      end else if (pop) begin
        rd_data_q <= mem_q[rd_ptr_d[PTR_W-1:0]];
      end
    end
  end

  assign fifo_level    = wr_ptr_q - rd_ptr_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = ~empty & ~echo_en;
  assign host_pop      = host.rd_valid & host.rd_ready;

  // Transmitter FSM; live_q holds off loads until the first cycle after reset release
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q;
  logic [3:0]           tx_tick_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 live_q;
  logic                 tx_idle, host_load, tx_load;
  logic [DATA_BITS-1:0] tx_word;

  assign tx_idle       = (tx_state_q == TxIdle) & live_q;
  assign echo_pop      = tx_idle & echo_en & ~empty;
  assign host.wr_ready = tx_idle & ~echo_en;
  assign host_load     = host.wr_ready & host.wr_valid;
  assign tx_load       = echo_pop | host_load;
  assign tx_word       = echo_en ? rd_data_q : host.wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      live_q     <= 1'b0;
    end else begin
      live_q <= 1'b1;
      unique case (tx_state_q)
        TxIdle: begin
          tx_q <= 1'b1;
          if (tx_load) begin
            tx_shift_q <= tx_word;
            tx_par_q   <= par_of(tx_word);
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= TxStart;
          end
        end
        TxStart: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_q       <= tx_shift_q[0];
              tx_state_q <= TxData;
            end
          end
        end
        TxData: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 4'd1;
              if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                tx_q       <= HAS_PAR ? tx_par_q : 1'b1;
                tx_state_q <= HAS_PAR ? TxParity : TxStop;
              end else begin
                tx_q <= tx_shift_q[1];
              end
            end
          end
        end
        TxParity: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_q       <= 1'b1;
              tx_state_q <= TxStop;
            end
          end
        end
        TxStop: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_state_q <= TxIdle;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign tx = tx_q;

  // Sticky error flags; a new event outranks a simultaneous clear
  logic overrun_q, frame_err_q, parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (overrun_ev) begin
        overrun_q <= 1'b1;
      end else if (clear_err) begin
        overrun_q <= 1'b0;
      end
      if (rx_frame_ev_q) begin
        frame_err_q <= 1'b1;
      end else if (clear_err) begin
        frame_err_q <= 1'b0;
      end
      if (rx_par_ev_q) begin
        parity_err_q <= 1'b1;
      end else if (clear_err) begin
        parity_err_q <= 1'b0;
      end
    end
  end

  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: an 8N1 depth-16 instance and an 8E1 depth-4 instance,
// both with one clock per oversample tick.
module tb_uart_echo_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx_n = 1'b1, tx_n, echo_n = 1'b0, clr_n = 1'b0;
  logic [4:0] lvl_n;
  logic       ovr_n, fe_n, pe_n;
  uart_echo_fifo_if #(.DATA_BITS(8)) host_n ();

  logic       rx_p = 1'b1, tx_p, echo_p = 1'b0, clr_p = 1'b0;
  logic [2:0] lvl_p;
  logic       ovr_p, fe_p, pe_p;
  uart_echo_fifo_if #(.DATA_BITS(8)) host_p ();

  uart_echo_fifo #(
    .CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)
  ) u_dut_n (
    .clk(clk), .rst_n(rst_n), .rx(rx_n), .tx(tx_n), .echo_en(echo_n), .host(host_n),
    .fifo_level(lvl_n), .overrun(ovr_n), .frame_err(fe_n), .parity_err(pe_n),
    .clear_err(clr_n)
  );

  uart_echo_fifo #(
    .CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .tx(tx_p), .echo_en(echo_p), .host(host_p),
    .fifo_level(lvl_p), .overrun(ovr_p), .frame_err(fe_p), .parity_err(pe_p),
    .clear_err(clr_p)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_p = v;
    else rx_n = v;
    repeat (16) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, parity (8E1 instance only), stop
  task automatic send_rx(input bit sel, input logic [7:0] d, input logic par,
                         input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel) drive_bit(sel, par);
    drive_bit(sel, stop);
    if (sel) rx_p = 1'b1;
    else rx_n = 1'b1;
  endtask

  task automatic wait_tx_fall(output int fall_cyc);
    int t = 0;
    while (tx_n !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("tx_fall_seen", 32'(t < 400), 1);
    fall_cyc = cyc;
  endtask

  // Called on the negedge where tx_n first reads low; samples each bit at mid-bit
  task automatic read_tx_frame(output logic start_b, output logic [7:0] d,
                               output logic stop_b);
    repeat (8) @(negedge clk);
    start_b = tx_n;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      d[i] = tx_n;
    end
    repeat (16) @(negedge clk);
    stop_b = tx_n;
  endtask

  task automatic pop_n();
    host_n.rd_ready = 1'b1;
    @(negedge clk);
    host_n.rd_ready = 1'b0;
  endtask

  task automatic pop_p();
    host_p.rd_ready = 1'b1;
    @(negedge clk);
    host_p.rd_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       sb, pb;
    logic [7:0] db;
    int         f, len, t;
    logic [7:0] words [5];

    words[0] = 8'h10; words[1] = 8'h21; words[2] = 8'h32; words[3] = 8'h43;
    words[4] = 8'h54;
    host_n.wr_data = '0; host_n.wr_valid = 1'b0; host_n.rd_ready = 1'b0;
    host_p.wr_data = '0; host_p.wr_valid = 1'b0; host_p.rd_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_n", tx_n, 1);
    check("rst_wr_ready_n", host_n.wr_ready, 0);
    check("rst_rd_valid_n", host_n.rd_valid, 0);
    check("rst_rd_data_n", host_n.rd_data, 0);
    check("rst_level_n", lvl_n, 0);
    check("rst_flags_n", {ovr_n, fe_n, pe_n}, 0);
    check("rst_tx_p", tx_p, 1);
    check("rst_level_p", lvl_p, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("wr_ready_after_rst", host_n.wr_ready, 1);

    // Host-mode receive and pop
    send_rx(0, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("a5_level", lvl_n, 1);
    check("a5_rd_valid", host_n.rd_valid, 1);
    check("a5_rd_data", host_n.rd_data, 8'hA5);
    check("a5_flags", {ovr_n, fe_n, pe_n}, 0);
    pop_n();
    check("a5_pop_level", lvl_n, 0);
    check("a5_pop_rd_valid", host_n.rd_valid, 0);

    // Short low glitch must not start a frame
    rx_n = 1'b0;
    repeat (4) @(negedge clk);
    rx_n = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_level", lvl_n, 0);
    check("glitch_flags", {ovr_n, fe_n, pe_n}, 0);
    send_rx(0, 8'h5A, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("post_glitch_data", host_n.rd_data, 8'h5A);
    pop_n();

    // Echo mode; echo_en drops mid-frame and must not cut the frame short
    echo_n = 1'b1;
    @(negedge clk);
    check("echo_wr_ready", host_n.wr_ready, 0);
    fork
      send_rx(0, 8'h3C, 1'b0, 1'b1);
      begin
        wait_tx_fall(f);
        check("echo_level_after_load", lvl_n, 0);
        echo_n = 1'b0;
        read_tx_frame(sb, db, pb);
        check("echo_start", sb, 0);
        check("echo_data", db, 8'h3C);
        check("echo_stop", pb, 1);
        t = 0;
        while (host_n.wr_ready !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        len = cyc - f;
        check("echo_frame_len", len, 160);
      end
    join
    repeat (20) @(negedge clk);

    // Host-mode transmit
    host_n.wr_data = 8'hC3;
    host_n.wr_valid = 1'b1;
    @(negedge clk);
    host_n.wr_valid = 1'b0;
    check("host_tx_busy", host_n.wr_ready, 0);
    check("host_tx_low", tx_n, 0);
    read_tx_frame(sb, db, pb);
    check("host_tx_start", sb, 0);
    check("host_tx_data", db, 8'hC3);
    check("host_tx_stop", pb, 1);
    repeat (20) @(negedge clk);

    // Even parity instance: wrong parity bit for 0x01
    send_rx(1, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("par_err", pe_p, 1);
    check("par_frame_err", fe_p, 0);
    check("par_level", lvl_p, 1);
    check("par_data", host_p.rd_data, 8'h01);
    clr_p = 1'b1;
    @(negedge clk);
    clr_p = 1'b0;
    check("par_cleared", pe_p, 0);
    pop_p();

    // Low stop bit
    send_rx(1, 8'h55, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("frame_err", fe_p, 1);
    check("frame_par_ok", pe_p, 0);
    check("frame_data", host_p.rd_data, 8'h55);
    clr_p = 1'b1;
    @(negedge clk);
    clr_p = 1'b0;
    pop_p();
    check("frame_cleared", {ovr_p, fe_p, pe_p}, 0);

    // Overrun: five words into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_rx(1, words[i], ^words[i], 1'b1);
    repeat (2) @(negedge clk);
    check("ovr_level", lvl_p, 4);
    check("ovr_flag", ovr_p, 1);
    check("ovr_other_flags", {fe_p, pe_p}, 0);
    check("ovr_head", host_p.rd_data, 8'h10);
    clr_p = 1'b1;
    @(negedge clk);
    clr_p = 1'b0;
    check("ovr_cleared", ovr_p, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_pop%0d", i), host_p.rd_data, words[i]);
      pop_p();
    end
    check("ovr_drained", lvl_p, 0);

    // Reset in the middle of a transmit frame with a word buffered
    send_rx(0, 8'h77, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_level", lvl_n, 1);
    host_n.wr_data = 8'h00;
    host_n.wr_valid = 1'b1;
    @(negedge clk);
    host_n.wr_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_tx_low", tx_n, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_n, 1);
    check("mid_rst_level", lvl_n, 0);
    check("mid_rst_wr_ready", host_n.wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_wr_ready", host_n.wr_ready, 1);
    check("post_rst_rd_valid", host_n.rd_valid, 0);
    check("post_rst_tx", tx_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
